seq_mult_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one unsigned sequential right-shift multiplier among NREQ requesters. It accepts req/operand pairs and grants one requester at a time. It drives the multiplier's operand, load and reset pins, counts out the multiply latency, then returns the product with a one-cycle done pulse to the granted requester. It sits between the requesting datapath blocks and the single multiplier instance.

---
 rtl/seq_mult_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_seq_mult_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among NREQ requesters.
// Optional: define SEQ_MULT_ARB_ZERO_BYPASS_EN to skip the multiplier when an operand is zero.
module seq_mult_rr_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned MULT_CYCLES = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      product_out,
    output logic                    busy,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    output logic                    mult_reset,
    output logic                    mult_load,
    input  logic [2*WIDTH-1:0]      mult_product
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            mult_reset_q;

    logic            sel_valid;
    logic [IW-1:0]   sel_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    int unsigned     cand;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First pending request at or above rr_ptr, wrapping around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(rr_ptr) + k) % NREQ;
            if (!sel_valid && req[IW'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
        sel_a = a_in[sel_idx*WIDTH +: WIDTH];
        sel_b = b_in[sel_idx*WIDTH +: WIDTH];
    end

    assign mult_reset = mult_reset_q | reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            rr_ptr       <= '0;
            idx          <= '0;
            cnt          <= '0;
            gnt          <= '0;
            done         <= '0;
            product_out  <= '0;
            busy         <= 1'b0;
            mult_a       <= '0;
            mult_b       <= '0;
            mult_reset_q <= 1'b0;
            mult_load    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (sel_valid) begin
                        idx    <= sel_idx;
                        mult_a <= sel_a;
                        mult_b <= sel_b;
                        busy   <= 1'b1;
                        gnt    <= onehot(sel_idx);
`ifdef SEQ_MULT_ARB_ZERO_BYPASS_EN
                        if (sel_a == '0 || sel_b == '0) begin
                            state       <= StDone;
                            done        <= onehot(sel_idx);
                            product_out <= '0;
                            rr_ptr      <= rr_next(sel_idx);
                        end else begin
                            state        <= StLoad;
                            mult_reset_q <= 1'b1;
                            mult_load    <= 1'b1;
                        end
`else
                        state        <= StLoad;
                        mult_reset_q <= 1'b1;
                        mult_load    <= 1'b1;
`endif
                    end
                end
                StLoad: begin
                    state        <= StRun;
                    cnt          <= '0;
                    mult_reset_q <= 1'b0;
                end
                StRun: begin
                    if (cnt == CW'(MULT_CYCLES - 1)) begin
                        state       <= StDone;
                        mult_load   <= 1'b0;
                        product_out <= mult_product;
                        done        <= onehot(idx);
                        rr_ptr      <= rr_next(idx);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_rr_arbiter.sv
// Scoreboard bench for seq_mult_rr_arbiter with a behavioural sequential multiplier.
module tb_seq_mult_rr_arbiter;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned WIDTH       = 6;
    localparam int unsigned MULT_CYCLES = 6;
    localparam int LAT  = MULT_CYCLES + 2;
    localparam int SPAC = MULT_CYCLES + 3;
`ifdef SEQ_MULT_ARB_ZERO_BYPASS_EN
    localparam int LAT_ZERO    = 1;
    localparam int STROBE_ZERO = 0;
`else
    localparam int LAT_ZERO    = MULT_CYCLES + 2;
    localparam int STROBE_ZERO = 1;
`endif

    logic                    clock;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   a_in;
    logic [NREQ*WIDTH-1:0]   b_in;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [2*WIDTH-1:0]      product_out;
    logic                    busy;
    logic [WIDTH-1:0]        mult_a;
    logic [WIDTH-1:0]        mult_b;
    logic                    mult_reset;
    logic                    mult_load;
    logic [2*WIDTH-1:0]      mult_product;

    typedef struct {
        int unsigned        idx;
        logic [2*WIDTH-1:0] prod;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [NREQ-1:0] mon_oh;
    int total = 0;
    int bad   = 0;

    seq_mult_rr_arbiter #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .done         (done),
        .product_out  (product_out),
        .busy         (busy),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_reset   (mult_reset),
        .mult_load    (mult_load),
        .mult_product (mult_product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Product is only correct once enough enable cycles have followed the load strobe.
    logic [2*WIDTH-1:0] m_acc = '0;
    int                 m_k   = 0;
    always @(posedge clock) begin
        if (mult_reset) begin
            m_acc <= mult_a * mult_b;
            m_k   <= 0;
        end else if (mult_load) begin
            m_k <= m_k + 1;
        end
    end
    assign mult_product = (m_k >= MULT_CYCLES - 1) ? m_acc : ~m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done != '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%b required=none", done);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                check("done_vec", 32'(done), 32'(mon_oh));
                check("gnt_at_done", 32'(gnt), 32'(mon_oh));
                check("product", 32'(product_out), 32'(mon_e.prod));
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic push(input int i, input int p);
        exp_t e;
        e.idx  = i;
        e.prod = (2*WIDTH)'(p);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc, output int gcyc, output bit strobed);
        cyc = 0;
        gcyc = 0;
        strobed = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            cyc++;
            if (gnt[i]) gcyc++;
            if (mult_reset || mult_load) strobed = 1'b1;
            if (done[i]) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout req=%0d actual=none required=done", i);
    endtask

    int c, g, g3;
    bit s;
    int order[5] = '{0, 1, 2, 3, 0};
    int prods[4] = '{27, 200, 561, 63};

    initial begin
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clock);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_prod", 32'(product_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mult_reset", 32'(mult_reset), 1);
        check("rst_mult_load", 32'(mult_load), 0);
        check("rst_mult_a", 32'(mult_a), 0);
        reset = 1'b0;

        // Single request
        @(negedge clock);
        set_op(0, 35, 26);
        req = 4'b0001;
        push(0, 910);
        wait_done(0, c, g, s);
        check("t1_latency", c, LAT);
        check("t1_gnt_cycles", g, LAT);
        req = '0;
        @(negedge clock);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_gnt_after", 32'(gnt), 0);
        check("t1_prod_hold", 32'(product_out), 910);

        // Simultaneous requests 1 and 2 from reset
        do_reset();
        set_op(1, 5, 7);
        set_op(2, 63, 63);
        req = 4'b0110;
        push(1, 35);
        push(2, 3969);
        wait_done(1, c, g, s);
        check("t2_lat1", c, LAT);
        req = 4'b0100;
        wait_done(2, c, g, s);
        check("t2_spacing", c, SPAC);
        req = '0;

        // All requesters held high: order 0,1,2,3,0
        do_reset();
        set_op(0, 3, 9);
        set_op(1, 10, 20);
        set_op(2, 17, 33);
        set_op(3, 63, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push(order[k], prods[order[k]]);
        for (int k = 0; k < 5; k++) begin
            wait_done(order[k], c, g, s);
            check("t3_spacing", c, (k == 0) ? LAT : SPAC);
        end
        req = '0;

        // Reset during RUN with cnt=3; rr_ptr is 1 beforehand
        @(negedge clock);
        set_op(0, 12, 13);
        set_op(3, 7, 9);
        req = 4'b0001;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        req   = '0;
        #1;
        check("t4_gnt_clr", 32'(gnt), 0);
        check("t4_busy_clr", 32'(busy), 0);
        check("t4_prod_clr", 32'(product_out), 0);
        check("t4_mult_load_clr", 32'(mult_load), 0);
        check("t4_mult_reset_hi", 32'(mult_reset), 1);
        @(negedge clock);
        check("t4_mult_reset_hold", 32'(mult_reset), 1);
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b1001;
        push(0, 156);
        #1;
        check("t4_mult_reset_low", 32'(mult_reset), 0);
        wait_done(0, c, g, s);
        check("t4_latency", c, LAT);
        req = '0;

        // Requester 3 drops req two cycles after grant; operands changed too
        @(negedge clock);
        set_op(3, 50, 41);
        req = 4'b1000;
        push(3, 2050);
        repeat (3) @(negedge clock);
        req = '0;
        set_op(3, 1, 1);
        wait_done(3, c, g, s);
        check("t5_latency", c + 3, LAT);
        g3 = 0;
        repeat (12) begin
            @(negedge clock);
            if (gnt[3] || busy) g3++;
        end
        check("t5_no_regrant", g3, 0);

        // Zero operand
        @(negedge clock);
        set_op(0, 0, 45);
        req = 4'b0001;
        push(0, 0);
        wait_done(0, c, g, s);
        check("t6_latency", c, LAT_ZERO);
        check("t6_strobed", 32'(s), STROBE_ZERO);
        req = '0;
        repeat (3) @(negedge clock);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
